// File: rtl/edge_sync_pkg.sv
// Shared definitions for the multi-channel edge synchroniser.
package edge_sync_pkg;

    // Per-channel edge_mode encoding
    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Debounce counter width; at least one bit so the declaration stays legal for n <= 1
    function automatic int unsigned deb_cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/edge_sync_ch.sv
// One channel: synchroniser chain, optional debounce, edge detect and sticky flags.
module edge_sync_ch
    import edge_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [1:0] edge_mode,
    input  logic       evt_clr,
    output logic       level_sync,
    output logic       pulse,
    output logic       evt_pend,
    output logic       evt_ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   lvl_q;
    logic                   lvl_prev_q;
    logic                   pulse_q;
    logic                   pend_q;
    logic                   ovf_q;
    logic                   detect;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYC <= 1) begin : g_nofilt
        // Filtered level simply follows the synchroniser output
        always_ff @(posedge clk) begin
            if (rst) begin
                lvl_q <= 1'b0;
            end else begin
                lvl_q <= sync_out;
            end
        end
    end else begin : g_filt
        localparam int unsigned   CntW    = deb_cnt_width(DEBOUNCE_CYC);
        localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

        logic [CntW-1:0] cnt_q;

        // Count consecutive disagreeing cycles; toggle the level on the Nth one
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync_out != lvl_q) begin
                if (cnt_q == CntLast) begin
                    cnt_q <= '0;
                    lvl_q <= ~lvl_q;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Select the detect condition from the current mode; off suppresses everything
    always_comb begin
        detect = 1'b0;
        unique case (edge_mode)
            EDGE_OFF:  detect = 1'b0;
            EDGE_RISE: detect = lvl_q & ~lvl_prev_q;
            EDGE_FALL: detect = ~lvl_q & lvl_prev_q;
            EDGE_BOTH: detect = lvl_q ^ lvl_prev_q;
        endcase
    end

    // Register the pulse and update sticky flags; a same-cycle detect beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
            pend_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            lvl_prev_q <= lvl_q;
            pulse_q    <= detect;
            if (detect) begin
                pend_q <= 1'b1;
                if (evt_clr) begin
                    ovf_q <= 1'b0;
                end else if (pend_q) begin
                    ovf_q <= 1'b1;
                end
            end else if (evt_clr) begin
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
        end
    end

    assign level_sync = lvl_q;
    assign pulse      = pulse_q;
    assign evt_pend   = pend_q;
    assign evt_ovf    = ovf_q;

endmodule

// File: rtl/edge_sync_multi.sv
// Multi-channel edge synchroniser: NUM_CH independent channels plus an OR'd interrupt.
module edge_sync_multi
    import edge_sync_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   din,
    input  logic [2*NUM_CH-1:0] edge_mode,
    input  logic [NUM_CH-1:0]   evt_clr,
    output logic [NUM_CH-1:0]   level_sync,
    output logic [NUM_CH-1:0]   pulse,
    output logic [NUM_CH-1:0]   evt_pend,
    output logic [NUM_CH-1:0]   evt_ovf,
    output logic                irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_sync_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .edge_mode  (edge_mode[2*i+1:2*i]),
            .evt_clr    (evt_clr[i]),
            .level_sync (level_sync[i]),
            .pulse      (pulse[i]),
            .evt_pend   (evt_pend[i]),
            .evt_ovf    (evt_ovf[i])
        );
    end

    // Interrupt straight from the pending registers
    assign irq = |evt_pend;

endmodule

// File: tb/tb_edge_sync_multi.sv
// Self-checking bench: pulse scoreboard plus per-scenario inline flag/level checks.
module tb_edge_sync_multi;
    import edge_sync_pkg::*;

    localparam int NCH = 4;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] din, din_db, evt_clr, evt_clr_db;
    logic [2*NCH-1:0] edge_mode;
    logic [NCH-1:0] level_sync, pulse, evt_pend, evt_ovf;
    logic [NCH-1:0] level_sync_db, pulse_db, evt_pend_db, evt_ovf_db;
    logic           irq, irq_db;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    ev_t exp_q[$];
    ev_t exp_db_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edge_sync_multi u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .edge_mode  (edge_mode),
        .evt_clr    (evt_clr),
        .level_sync (level_sync),
        .pulse      (pulse),
        .evt_pend   (evt_pend),
        .evt_ovf    (evt_ovf),
        .irq        (irq)
    );

    edge_sync_multi #(.DEBOUNCE_CYC(4)) u_dut_db (
        .clk        (clk),
        .rst        (rst),
        .din        (din_db),
        .edge_mode  (edge_mode),
        .evt_clr    (evt_clr_db),
        .level_sync (level_sync_db),
        .pulse      (pulse_db),
        .evt_pend   (evt_pend_db),
        .evt_ovf    (evt_ovf_db),
        .irq        (irq_db)
    );

    // Scoreboard: every observed pulse must match the head of the expected queue
    always @(negedge clk) begin
        ev_t e;
        for (int i = 0; i < NCH; i++) begin
            if (pulse[i] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_pulse: got pulse ch%0d cyc%0d, required none", i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ch !== i || e.cyc !== cyc) begin
                        failures++;
                        $display("FAIL sb_pulse: got ch%0d cyc%0d, required ch%0d cyc%0d",
                                 i, cyc, e.ch, e.cyc);
                    end
                end
            end
            if (pulse_db[i] === 1'b1) begin
                checks++;
                if (exp_db_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_pulse_db: got pulse ch%0d cyc%0d, required none", i, cyc);
                end else begin
                    e = exp_db_q.pop_front();
                    if (e.ch !== i || e.cyc !== cyc) begin
                        failures++;
                        $display("FAIL sb_pulse_db: got ch%0d cyc%0d, required ch%0d cyc%0d",
                                 i, cyc, e.ch, e.cyc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({level_sync, pulse, evt_pend, evt_ovf, irq} !== '0) begin
            failures++;
            $display("FAIL reset_main: got %h, required 0",
                     {level_sync, pulse, evt_pend, evt_ovf, irq});
        end
        checks++;
        if ({level_sync_db, pulse_db, evt_pend_db, evt_ovf_db, irq_db} !== '0) begin
            failures++;
            $display("FAIL reset_db: got %h, required 0",
                     {level_sync_db, pulse_db, evt_pend_db, evt_ovf_db, irq_db});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rise();
        int j;
        @(posedge clk); #1;
        j = cyc;
        din[0] = 1'b1;
        exp_q.push_back('{ch: 0, cyc: j + 4});
        repeat (3) @(negedge clk);
        checks++;
        if (level_sync[0] !== 1'b0) begin
            failures++;
            $display("FAIL rise_level_early: got %b, required 0", level_sync[0]);
        end
        @(negedge clk);
        checks++;
        if (level_sync[0] !== 1'b1) begin
            failures++;
            $display("FAIL rise_level: got %b, required 1", level_sync[0]);
        end
        @(negedge clk);
        checks++;
        if (evt_pend[0] !== 1'b1 || irq !== 1'b1 || evt_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL rise_flags: got pend=%b irq=%b ovf=%b, required 1 1 0",
                     evt_pend[0], irq, evt_ovf[0]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rise_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_both_edges();
        int j;
        @(posedge clk); #1;
        j = cyc;
        din[1] = 1'b1;
        exp_q.push_back('{ch: 1, cyc: j + 4});
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (evt_pend[1] !== 1'b1 || evt_ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL both_first: got pend=%b ovf=%b, required 1 0", evt_pend[1], evt_ovf[1]);
        end
        din[1] = 1'b0;
        exp_q.push_back('{ch: 1, cyc: j + 24});
        repeat (8) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL both_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (evt_pend[1] !== 1'b1 || evt_ovf[1] !== 1'b1) begin
            failures++;
            $display("FAIL both_ovf: got pend=%b ovf=%b, required 1 1", evt_pend[1], evt_ovf[1]);
        end
    endtask

    task automatic test_debounce();
        int  j;
        logic seen;
        // Short glitch must be swallowed
        @(posedge clk); #1;
        din_db[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        din_db[2] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | level_sync_db[2];
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL deb_glitch: got level high, required stays 0");
        end
        // Six-cycle high passes through
        @(posedge clk); #1;
        j = cyc;
        din_db[2] = 1'b1;
        exp_db_q.push_back('{ch: 2, cyc: j + 7});
        repeat (6) @(negedge clk);
        checks++;
        if (level_sync_db[2] !== 1'b0) begin
            failures++;
            $display("FAIL deb_level_early: got %b, required 0", level_sync_db[2]);
        end
        @(posedge clk); #1;
        din_db[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (level_sync_db[2] !== 1'b1) begin
            failures++;
            $display("FAIL deb_level: got %b, required 1", level_sync_db[2]);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (exp_db_q.size() != 0 || level_sync_db[2] !== 1'b0) begin
            failures++;
            $display("FAIL deb_end: got outstanding=%0d level=%b, required 0 0",
                     exp_db_q.size(), level_sync_db[2]);
            exp_db_q.delete();
        end
    endtask

    task automatic test_clear();
        int j;
        // Clear without detect on ch1
        @(posedge clk); #1;
        evt_clr[1] = 1'b1;
        @(posedge clk); #1;
        evt_clr[1] = 1'b0;
        checks++;
        if (evt_pend[1] !== 1'b0 || evt_ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL clr_ch1: got pend=%b ovf=%b, required 0 0", evt_pend[1], evt_ovf[1]);
        end
        // Clear coinciding with a new detect on ch0 (pend already set)
        j = cyc;
        edge_mode[1:0] = EDGE_BOTH;
        din[0] = 1'b0;
        exp_q.push_back('{ch: 0, cyc: j + 4});
        repeat (3) @(posedge clk);
        #1;
        evt_clr[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (evt_pend[0] !== 1'b1 || evt_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_same_cycle: got pend=%b ovf=%b, required 1 0",
                     evt_pend[0], evt_ovf[0]);
        end
        @(posedge clk); #1;
        evt_clr[0] = 1'b0;
        checks++;
        if (evt_pend[0] !== 1'b0 || evt_ovf[0] !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: got pend=%b ovf=%b irq=%b, required 0 0 0",
                     evt_pend[0], evt_ovf[0], irq);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL clr_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mode_off();
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            din[3] = ~din[3];
            repeat (4) @(negedge clk);
            checks++;
            if (level_sync[3] !== din[3]) begin
                failures++;
                $display("FAIL off_level%0d: got %b, required %b", t, level_sync[3], din[3]);
            end
            repeat (4) @(posedge clk);
        end
        #1;
        edge_mode[7:6] = EDGE_RISE;
        repeat (8) @(negedge clk);
        checks++;
        if (evt_pend[3] !== 1'b0 || evt_ovf[3] !== 1'b0) begin
            failures++;
            $display("FAIL off_flags: got pend=%b ovf=%b, required 0 0", evt_pend[3], evt_ovf[3]);
        end
    endtask

    task automatic test_reset_mid();
        int j;
        @(posedge clk); #1;
        j = cyc;
        din[2] = 1'b1;
        exp_q.push_back('{ch: 2, cyc: j + 4});
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (level_sync[2] !== 1'b1 || evt_pend[2] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got level=%b pend=%b, required 1 1",
                     level_sync[2], evt_pend[2]);
        end
        j = cyc;
        edge_mode[1:0] = EDGE_RISE;
        din[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({level_sync, pulse, evt_pend, evt_ovf, irq} !== '0) begin
            failures++;
            $display("FAIL rstmid_zero: got %h, required 0",
                     {level_sync, pulse, evt_pend, evt_ovf, irq});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back('{ch: 0, cyc: j + 7});
        exp_q.push_back('{ch: 2, cyc: j + 7});
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (evt_pend !== 4'b0101 || evt_ovf !== 4'b0000 || irq !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_flags: got pend=%b ovf=%b irq=%b, required 0101 0000 1",
                     evt_pend, evt_ovf, irq);
        end
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_db     = '0;
        evt_clr    = '0;
        evt_clr_db = '0;
        edge_mode  = {EDGE_OFF, EDGE_RISE, EDGE_BOTH, EDGE_RISE};
        test_reset();
        test_rise();
        test_both_edges();
        test_debounce();
        test_clear();
        test_mode_off();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
